dff_sync_rst: RTL and testbench
===============================

// Module: dff_sync_rst
//
// PURPOSE
//   Positive-edge D flip-flop with synchronous, active-high reset and complementary outputs.
//   Generic storage primitive for registering single control bits or narrow buses.
//   Q follows D one clock edge later; Qn is always the bitwise complement of Q.
//   Leaf cell: no internal submodules, no handshakes.
//
// PARAMETERS
//   WIDTH        1    data width in bits (>= 1)
//   RESET_VALUE  '0   value loaded into Q on reset; WIDTH bits wide
//
// PORTS
//   CLK   input   1      clock; all state changes on rising edge only
//   RST   input   1      synchronous reset, active-high
//   D     input   WIDTH  data input, sampled on rising CLK
//   Q     output  WIDTH  registered data
//   Qn    output  WIDTH  bitwise complement of Q
//
// BEHAVIOUR
//   Interface: one clock (CLK); reset (RST) is synchronous and active-high.
//   - Rising edge of CLK with RST=1: Q <= RESET_VALUE, regardless of D.
//   - Rising edge of CLK with RST=0: Q <= D.
//   - Latency: exactly 1 cycle from D sampled to Q.
//   - Between rising edges, Q holds its value. D glitches or changes between edges have
//     no effect. The falling edge has no effect.
//   - RST asserted between edges has no effect until the next rising edge (no async path).
//   - Qn = ~Q, purely combinational from the register.
//     Qn never equals Q in any bit, including during reset.
//   - Reset values: Q = RESET_VALUE and Qn = ~RESET_VALUE after the first reset edge.
//   - Power-up (simulation): the register initialises to RESET_VALUE.
//     Q and Qn are therefore defined (Q=0, Qn=1 by default) before any clock edge.
//     This also holds if RST is never asserted.
//   - D = X/Z at a sampling edge propagates X to Q and Qn; no masking.
//   - Simultaneous RST=1 and a D change at the same edge: reset wins.
//   - Reset deasserted at an edge: that edge still resets.
//     The first D capture happens on the following edge.
//   - No enable, no scan. Width rules: D, Q and Qn are all exactly WIDTH bits.
//
// TESTING
//   (CLK period 10, rising edges at t=5,15,25,...)
//   1. Power-up: no clock edge yet, RST=0, D=0 -> at t=0 Q=0, Qn=1.
//   2. Capture: D=0 until t=20, D=1 at t=20
//      -> Q stays 0 at t=15; Q=1, Qn=0 after the t=25 edge; held at t=35.
//   3. Release: D=0 at t=40 -> Q=0, Qn=1 after the t=45 edge.
//      D pulsed 1 during t=46..54 only -> Q remains 0.
//   4. Sync reset: Q=1, RST=1 asserted at t=62 (mid-cycle)
//      -> Q stays 1 until t=65; Q=0 after t=65 even with D=1.
//      RST=0 at t=70 -> Q=1 after t=75.
//   5. Parameterised: WIDTH=8, RESET_VALUE=8'hA5. Reset -> Q=8'hA5, Qn=8'h5A.
//      D=8'h3C -> Q=8'h3C, Qn=8'hC3 one edge later.
//   6. Checker every edge: Q == $past(RST) ? RESET_VALUE : $past(D), and Qn == ~Q always.

Source files
------------

// File: rtl/dff_sync_rst.sv
// dff_sync_rst: rising-edge D flip-flop with synchronous active-high reset
// and complementary outputs. Generic storage for control bits or narrow buses.
//
// Parameters
//   WIDTH        data width in bits (>= 1)
//   RESET_VALUE  value loaded into Q on a reset edge and at power-up
//
// Ports
//   CLK  in   1      clock; state changes only on the rising edge
//   RST  in   1      synchronous reset, active-high
//   D    in   WIDTH  data input, sampled on rising CLK
//   Q    out  WIDTH  registered data (one-cycle latency from D)
//   Qn   out  WIDTH  bitwise complement of Q
module dff_sync_rst #(
  parameter int unsigned          WIDTH       = 1,
  parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn
);

  logic [WIDTH-1:0] q_d;
  // Declaration initialiser gives a defined power-up value even if RST is never
  // asserted; it maps to the register's init value on FPGA targets.
  logic [WIDTH-1:0] q_q = RESET_VALUE;

  // Reset has priority over data; X on D is passed through unmasked.
  always_comb begin
    q_d = D;
    if (RST) begin
      q_d = RESET_VALUE;
    end
  end

  always_ff @(posedge CLK) begin
    q_q <= q_d;
  end

  assign Q  = q_q;
  assign Qn = ~q_q;

endmodule

// File: tb/tb_dff_sync_rst.sv
// Bench for dff_sync_rst: a 1-bit default instance and an 8-bit instance with
// RESET_VALUE 8'hA5 driven by shared reset. Expected Q after each edge is the
// rule "RST sampled high -> RESET_VALUE, else sampled D"; between edges Q must hold.
module tb_dff_sync_rst;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       d1  = 1'b0;
  logic [7:0] d8  = 8'h00;
  logic       q1, qn1;
  logic [7:0] q8, qn8;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic       exp_q1;
  logic [7:0] exp_q8;

  always #5 clk = ~clk;

  dff_sync_rst u_dut1 (
    .CLK (clk),
    .RST (rst),
    .D   (d1),
    .Q   (q1),
    .Qn  (qn1)
  );

  dff_sync_rst #(
    .WIDTH       (8),
    .RESET_VALUE (8'hA5)
  ) u_dut8 (
    .CLK (clk),
    .RST (rst),
    .D   (d8),
    .Q   (q8),
    .Qn  (qn8)
  );

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".q1"},  {7'b0, q1},  {7'b0, exp_q1});
    check_eq({tag, ".qn1"}, {7'b0, qn1}, {7'b0, ~exp_q1});
    check_eq({tag, ".q8"},  q8,  exp_q8);
    check_eq({tag, ".qn8"}, qn8, ~exp_q8);
  endtask

  // Apply inputs at the falling edge, check #1 after the rising edge, then
  // optionally scramble inputs mid-cycle and confirm the outputs hold.
  task automatic step(input logic r, input logic a, input logic [7:0] b, input bit glitch);
    @(negedge clk);
    rst = r;
    d1  = a;
    d8  = b;
    @(posedge clk);
    exp_q1 = r ? 1'b0  : a;
    exp_q8 = r ? 8'hA5 : b;
    #1;
    check_all("edge");
    if (glitch) begin
      rst = 1'($urandom);
      d1  = 1'($urandom);
      d8  = 8'($urandom);
      #2;
      check_all("hold");
    end
  endtask

  initial begin
    // Power-up: defined outputs before any clock edge, RST never asserted yet.
    exp_q1 = 1'b0;
    exp_q8 = 8'hA5;
    #1;
    check_all("powerup");

    // Capture, hold and release.
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h3C, 1'b0);
    step(1'b0, 1'b1, 8'h3C, 1'b1);
    step(1'b0, 1'b0, 8'hC3, 1'b1);
    // Reset wins over D; deasserting edge still resets only when RST sampled high.
    step(1'b1, 1'b1, 8'hFF, 1'b1);
    step(1'b1, 1'b1, 8'h12, 1'b0);
    step(1'b0, 1'b1, 8'h3C, 1'b0);

    // Randomised traffic with occasional resets and mid-cycle glitches.
    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(7, 0) == 0), 1'($urandom), 8'($urandom), 1'($urandom));
    end

    // Unknown D propagates to Q and Qn; reset then recovers.
    step(1'b0, 1'bx, 8'hxx, 1'b0);
    step(1'b1, 1'bx, 8'hxx, 1'b0);
    step(1'b0, 1'b1, 8'h5A, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
